// File: rtl/dmem_pkg.sv
// Shared MemOp codes, FSM state type and lane extract/merge helpers for the
// data-memory responder.
package dmem_pkg;

   localparam logic [2:0] MOP_LB  = 3'b000;
   localparam logic [2:0] MOP_LH  = 3'b001;
   localparam logic [2:0] MOP_LW  = 3'b010;
   localparam logic [2:0] MOP_LBU = 3'b100;
   localparam logic [2:0] MOP_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      ACK  = 2'd2
   } dmem_state_t;

   function automatic logic op_is_byte(input logic [2:0] op);
      return (op == MOP_LB) || (op == MOP_LBU);
   endfunction

   function automatic logic op_is_half(input logic [2:0] op);
      return (op == MOP_LH) || (op == MOP_LHU);
   endfunction

   function automatic logic op_is_sub(input logic [2:0] op);
      return op_is_byte(op) || op_is_half(op);
   endfunction

   // Reserved codes behave as word accesses but are still flagged.
   function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lane);
      logic err;
      err = 1'b0;
      if (op_is_half(op)) err = lane[0];
      else if (op == MOP_LW) err = (lane != 2'b00);
      else if (!op_is_byte(op)) err = 1'b1;
      return err;
   endfunction

   function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                               input logic [2:0]  op,
                                               input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (op)
         MOP_LB:  res = {{24{b[7]}}, b};
         MOP_LBU: res = {24'h0, b};
         MOP_LH:  res = {{16{h[15]}}, h};
         MOP_LHU: res = {16'h0, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lane);
      logic [31:0] res;
      res = old;
      if (op_is_byte(op)) begin
         res[{lane, 3'b000} +: 8] = wdata[7:0];
      end else if (op_is_half(op)) begin
         if (lane[1]) res[31:16] = wdata[15:0];
         else         res[15:0]  = wdata[15:0];
      end else begin
         res = wdata;
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-access bus: request handshake plus one-cycle response pulse.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_op, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_op, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_sram.sv
// Single-port synchronous-read word array; read-before-write on a shared
// address. Drop-in point for a vendor SRAM macro. Contents are never reset.
module dmem_sram #(
   parameter int DEPTH_WORDS = 4096,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clock_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clock_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request per two cycles, response pulse in N+1.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned/reserved accesses via resp_err.
//
// state | meaning
// IDLE  | ready; accept request, word stores written this cycle
// RD    | SRAM data valid; return load data or write merged sub-word store
// ACK   | word store completed; response pulse only
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096
) (
   input logic   clock,
   input logic   rstn,
   dmem_if.slave dmem
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_t state_q, state_d;
   logic          we_q,    we_d;
   logic [2:0]    op_q,    op_d;
   logic [1:0]    lane_q,  lane_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [AW-1:0] idx_q,   idx_d;
   logic          err_q,   err_d;

   logic          accept;
   logic          req_err;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata;

   logic          req_ready;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;

   logic          unused_addr_hi;

   assign unused_addr_hi = ^dmem.req_addr[31:AW+2];
   assign accept         = dmem.req_valid && (state_q == IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_err = op_misaligned(dmem.req_op, dmem.req_addr[1:0]);
`else
   assign req_err = 1'b0;
`endif

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         op_q    <= 3'b000;
         lane_q  <= 2'b00;
         wdata_q <= 32'h0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         op_q    <= op_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      op_d       = op_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      idx_d      = idx_q;
      err_d      = err_q;
      sram_we    = 1'b0;
      sram_addr  = dmem.req_addr[AW+1:2];
      sram_wdata = dmem.req_wdata;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      resp_err   = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               we_d    = dmem.req_we;
               op_d    = dmem.req_op;
               lane_d  = dmem.req_addr[1:0];
               wdata_d = dmem.req_wdata;
               idx_d   = dmem.req_addr[AW+1:2];
               err_d   = req_err;
               // Full-word stores need no old data, so they skip the read.
               if (dmem.req_we && !op_is_sub(dmem.req_op)) begin
                  sram_we = !req_err;
                  state_d = ACK;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            sram_addr  = idx_q;
            state_d    = IDLE;
            if (we_q) begin
               sram_we    = !err_q;
               sram_wdata = lane_merge(sram_rdata, wdata_q, op_q, lane_q);
            end else if (!err_q) begin
               resp_rdata = lane_extend(sram_rdata, op_q, lane_q);
            end
         end
         ACK: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dmem.req_ready  = req_ready;
   assign dmem.resp_valid = resp_valid;
   assign dmem.resp_rdata = resp_rdata;
   assign dmem.resp_err   = resp_err;

   dmem_sram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_sram (
      .clock_i(clock),
      .we_i   (sram_we),
      .addr_i (sram_addr),
      .wdata_i(sram_wdata),
      .rdata_o(sram_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: behavioural memory model plus directed and random traffic.
module tb_dmem_responder;

   logic clock = 1'b0;
   logic rstn  = 1'b0;

   dmem_if dmem ();

   dmem_responder dut (
      .clock(clock),
      .rstn (rstn),
      .dmem (dmem.slave)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int passed = 0;

   logic [31:0] mdl [4096];
   bit          pend = 0;
   bit          pend_err;
   logic [31:0] pend_rdata;
   bit          pend_wr;
   logic [11:0] pend_idx;
   logic [31:0] pend_word;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0;
   bit          last_dut_acc;
   int          n_resp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic bit m_err(input logic [2:0] op, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
      if (op == 3'b000 || op == 3'b100) return 0;
      if (op == 3'b001 || op == 3'b101) return a[0];
      if (op == 3'b010) return a[1:0] != 2'b00;
      return 1;
`else
      return (op == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   function automatic bit m_sub(input logic [2:0] op);
      return op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] op, input logic [31:0] a);
      logic [31:0] b, h;
      b = (w >> (8 * a[1:0])) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (op)
         3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] op, input logic [31:0] a);
      logic [31:0] mask;
      int sh;
      if (op == 3'b000 || op == 3'b100) begin
         sh = 8 * a[1:0];
         mask = 32'hFF << sh;
      end else begin
         sh = 16 * a[1];
         mask = 32'hFFFF << sh;
      end
      return (old & ~mask) | ((wd << sh) & mask);
   endfunction

   task automatic sample();
      @(negedge clock);
      chk("req_ready", {31'h0, dmem.req_ready}, pend ? 32'h0 : 32'h1);
      chk("resp_valid", {31'h0, dmem.resp_valid}, {31'h0, pend});
      chk("resp_rdata", dmem.resp_rdata, pend ? pend_rdata : 32'h0);
      chk("resp_err", {31'h0, dmem.resp_err}, pend ? {31'h0, pend_err} : 32'h0);
      if (dmem.resp_valid === 1'b1) begin
         n_resp++;
         last_rdata = dmem.resp_rdata;
         last_err   = dmem.resp_err;
      end
   endtask

   task automatic step(input bit v, input bit we, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd);
      logic [11:0] idx;
      logic [31:0] old;
      bit err;
      sample();
      last_dut_acc = v && (dmem.req_ready === 1'b1);
      if (pend && pend_wr) mdl[pend_idx] = pend_word;
      dmem.req_valid = v;
      dmem.req_we    = we;
      dmem.req_op    = op;
      dmem.req_addr  = a;
      dmem.req_wdata = wd;
      if (v && !pend) begin
         idx = a[13:2];
         old = mdl[idx];
         err = m_err(op, a);
         pend = 1;
         pend_wr = 0;
         pend_err = err;
         pend_rdata = 32'h0;
         if (!we) begin
            if (!err) pend_rdata = m_load(old, op, a);
         end else if (!err) begin
            if (m_sub(op)) begin
               pend_wr = 1;
               pend_idx = idx;
               pend_word = m_merge(old, wd, op, a);
            end else begin
               mdl[idx] = wd;
            end
         end
      end else begin
         pend = 0;
         pend_wr = 0;
      end
   endtask

   task automatic idle();
      step(0, 0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
      step(1, 1, op, a, wd);
      idle();
   endtask

   task automatic rd_lit(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] lit);
      step(1, 0, op, a, 32'h0);
      idle();
      chk(name, last_rdata, lit);
   endtask

   initial begin
      logic [5:0]  mask;
      logic [31:0] r, a;
      int          resp0;
      dmem.req_valid = 0;
      dmem.req_we    = 0;
      dmem.req_op    = 3'b000;
      dmem.req_addr  = 32'h0;
      dmem.req_wdata = 32'h0;
      repeat (3) @(negedge clock);
      chk("reset_ready", {31'h0, dmem.req_ready}, 32'h1);
      chk("reset_resp_valid", {31'h0, dmem.resp_valid}, 32'h0);
      chk("reset_rdata", dmem.resp_rdata, 32'h0);
      rstn = 1;

      for (int i = 0; i < 32; i++) wr(3'b010, 32'(i) << 2, $urandom());

      wr(3'b010, 32'h10, 32'hDEADBEEF);
      rd_lit("lw_deadbeef", 3'b010, 32'h10, 32'hDEADBEEF);

      wr(3'b010, 32'h10, 32'h11223344);
      wr(3'b000, 32'h13, 32'h00000080);
      rd_lit("lw_after_sb", 3'b010, 32'h10, 32'h80223344);
      rd_lit("lb_13", 3'b000, 32'h13, 32'hFFFFFF80);
      rd_lit("lbu_13", 3'b100, 32'h13, 32'h00000080);

      wr(3'b010, 32'h20, 32'h00000000);
      wr(3'b001, 32'h22, 32'h00008001);
      rd_lit("lh_22", 3'b001, 32'h22, 32'hFFFF8001);
      rd_lit("lhu_22", 3'b101, 32'h22, 32'h00008001);
      rd_lit("lw_after_sh", 3'b010, 32'h20, 32'h80010000);

      resp0 = n_resp;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 3'b010, 32'(i) << 2, 32'h0);
         mask[i] = last_dut_acc;
      end
      idle();
      chk("burst_accepts", {26'h0, mask}, 32'h15);
      chk("burst_resps", 32'(n_resp - resp0), 32'd3);

      wr(3'b010, 32'h30, 32'h12345678);
      step(1, 1, 3'b001, 32'h30, 32'h0000AAAA);
      sample();
      dmem.req_valid = 0;
      rstn = 0;
      #1;
      chk("rst_mid_ready", {31'h0, dmem.req_ready}, 32'h1);
      chk("rst_mid_valid", {31'h0, dmem.resp_valid}, 32'h0);
      chk("rst_mid_rdata", dmem.resp_rdata, 32'h0);
      chk("rst_mid_err", {31'h0, dmem.resp_err}, 32'h0);
      pend = 0;
      pend_wr = 0;
      @(negedge clock);
      rstn = 1;
      idle();
      rd_lit("lw_after_reset", 3'b010, 32'h30, 32'h12345678);

      wr(3'b010, 32'h40, 32'h55555555);
      step(1, 1, 3'b010, 32'h41, 32'hCAFEF00D);
      idle();
`ifdef DMEM_ALIGN_CHECK_EN
      chk("sw41_err", {31'h0, last_err}, 32'h1);
      rd_lit("lw40_after_sw41", 3'b010, 32'h40, 32'h55555555);
`else
      chk("sw41_err", {31'h0, last_err}, 32'h0);
      rd_lit("lw40_after_sw41", 3'b010, 32'h40, 32'hCAFEF00D);
`endif

      for (int i = 0; i < 600; i++) begin
         r = $urandom();
         a = (r & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
         step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
              3'($urandom_range(0, 7)), a, $urandom());
      end
      idle();
      idle();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
